lvds_tx_pixel_mapper: RTL and testbench

LVDS_TX_PIXEL_MAPPER -- requirements
Module: lvds_tx_pixel_mapper

---
 rtl/lvds_tx_pixel_mapper.sv | 170 +++++++++++++++++
 tb/tb_lvds_tx_pixel_mapper.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_tx_pixel_mapper.sv
// LVDS transmit pixel mapper: RGB/sync to 4 data lanes + clock lane.
// Optional frame-locked colour-bar / grey-ramp test pattern.
module lvds_tx_pixel_mapper #(
  parameter int MAP_MODE = 0,
  parameter int BAR_W    = 160,
  parameter int SYNC_INV = 0
) (
  input  logic       I_clk_1x,
  input  logic       I_rst,
  input  logic       I_de,
  input  logic       I_hs,
  input  logic       I_vs,
  input  logic [7:0] I_r,
  input  logic [7:0] I_g,
  input  logic [7:0] I_b,
  input  logic       I_test_en,
  input  logic       I_pat_sel,
  output logic [6:0] O_lane0,
  output logic [6:0] O_lane1,
  output logic [6:0] O_lane2,
  output logic [6:0] O_lane3,
  output logic [6:0] O_clk_lane,
  output logic       O_test_active
);

  localparam logic       INV      = 1'(SYNC_INV != 0);
  localparam logic [8:0] BAR_LAST = 9'(BAR_W - 1);
  localparam logic [10:0] PIX_MAX = 11'd2047;

  logic        hs_in;
  logic        vs_in;
  logic        vs_prev;
  logic        frame_start;
  logic        test_flag;
  logic        pat_q;
  logic        flag_nxt;
  logic        pat_nxt;
  logic [10:0] pix_cnt;
  logic [8:0]  bar_cnt;
  logic [2:0]  bar_idx;
  logic [23:0] bar_rgb;
  logic [23:0] pat_rgb;
  logic [23:0] rgb_sel;

  logic        s1_de;
  logic        s1_hs;
  logic        s1_vs;
  logic [7:0]  s1_r;
  logic [7:0]  s1_g;
  logic [7:0]  s1_b;

  logic [6:0]  map0;
  logic [6:0]  map1;
  logic [6:0]  map2;
  logic [6:0]  map3;

  assign O_clk_lane = 7'b1100011;

  // Sync polarity, frame-start detect and the flag value in force now.
  always_comb begin
    hs_in       = I_hs ^ INV;
    vs_in       = I_vs ^ INV;
    frame_start = vs_in & ~vs_prev;
    flag_nxt    = frame_start ? I_test_en : test_flag;
    pat_nxt     = frame_start ? I_pat_sel : pat_q;
  end

  // Colour-bar lookup by bar index.
  always_comb begin
    bar_rgb = 24'h000000;
    unique case (bar_idx)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      3'd7: bar_rgb = 24'h000000;
    endcase
  end

  // Pattern select and substitution; blanking is forced black in test mode.
  always_comb begin
    pat_rgb = pat_nxt ? {3{pix_cnt[7:0]}} : bar_rgb;
    if (!flag_nxt)
      rgb_sel = {I_r, I_g, I_b};
    else if (I_de)
      rgb_sel = pat_rgb;
    else
      rgb_sel = 24'h000000;
  end

  // Pixel and bar counters, cleared outside active video.
  always_ff @(posedge I_clk_1x) begin
    if (I_rst || !I_de) begin
      pix_cnt <= '0;
      bar_cnt <= '0;
      bar_idx <= '0;
    end else begin
      if (pix_cnt != PIX_MAX)
        pix_cnt <= pix_cnt + 11'd1;
      if (bar_cnt >= BAR_LAST) begin
        bar_cnt <= '0;
        if (bar_idx != 3'd7)
          bar_idx <= bar_idx + 3'd1;
      end else begin
        bar_cnt <= bar_cnt + 9'd1;
      end
    end
  end

  // Stage 1: registered inputs, frame-locked flag and pattern choice.
  always_ff @(posedge I_clk_1x) begin
    if (I_rst) begin
      vs_prev   <= 1'b0;
      test_flag <= 1'b0;
      pat_q     <= 1'b0;
      s1_de     <= 1'b0;
      s1_hs     <= 1'b0;
      s1_vs     <= 1'b0;
      s1_r      <= '0;
      s1_g      <= '0;
      s1_b      <= '0;
    end else begin
      vs_prev   <= vs_in;
      test_flag <= flag_nxt;
      pat_q     <= pat_nxt;
      s1_de     <= I_de;
      s1_hs     <= hs_in;
      s1_vs     <= vs_in;
      s1_r      <= rgb_sel[23:16];
      s1_g      <= rgb_sel[15:8];
      s1_b      <= rgb_sel[7:0];
    end
  end

  // Lane bit mapping; bit 0 is serialized first.
  always_comb begin
    if (MAP_MODE == 0) begin
      map0 = {s1_g[0], s1_r[5:0]};
      map1 = {s1_b[1:0], s1_g[5:1]};
      map2 = {s1_de, s1_vs, s1_hs, s1_b[5:2]};
      map3 = {1'b0, s1_b[7:6], s1_g[7:6], s1_r[7:6]};
    end else begin
      map0 = {s1_g[2], s1_r[7:2]};
      map1 = {s1_b[3:2], s1_g[7:3]};
      map2 = {s1_de, s1_vs, s1_hs, s1_b[7:4]};
      map3 = {1'b0, s1_b[1:0], s1_g[1:0], s1_r[1:0]};
    end
  end

  // Stage 2: registered lane words and aligned test indicator.
  always_ff @(posedge I_clk_1x) begin
    if (I_rst) begin
      O_lane0       <= '0;
      O_lane1       <= '0;
      O_lane2       <= '0;
      O_lane3       <= '0;
      O_test_active <= 1'b0;
    end else begin
      O_lane0       <= map0;
      O_lane1       <= map1;
      O_lane2       <= map2;
      O_lane3       <= map3;
      O_test_active <= test_flag;
    end
  end

endmodule

// File: tb/tb_lvds_tx_pixel_mapper.sv
// Directed bench for lvds_tx_pixel_mapper.
// VESA/BAR_W=4 instance plus JEIDA/SYNC_INV instance.
module tb_lvds_tx_pixel_mapper;

  logic       clk = 1'b0;
  logic       rst;
  logic       de, hs, vs;
  logic [7:0] r, g, b;
  logic       test_en, pat_sel;

  logic [6:0] la0, la1, la2, la3, clka;
  logic [6:0] lb0, lb1, lb2, lb3, clkb;
  logic       ta, tb;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lvds_tx_pixel_mapper #(
    .MAP_MODE(0), .BAR_W(4), .SYNC_INV(0)
  ) dut_a (
    .I_clk_1x(clk), .I_rst(rst), .I_de(de),
    .I_hs(hs), .I_vs(vs),
    .I_r(r), .I_g(g), .I_b(b),
    .I_test_en(test_en), .I_pat_sel(pat_sel),
    .O_lane0(la0), .O_lane1(la1),
    .O_lane2(la2), .O_lane3(la3),
    .O_clk_lane(clka), .O_test_active(ta)
  );

  lvds_tx_pixel_mapper #(
    .MAP_MODE(1), .BAR_W(4), .SYNC_INV(1)
  ) dut_b (
    .I_clk_1x(clk), .I_rst(rst), .I_de(de),
    .I_hs(hs), .I_vs(vs),
    .I_r(r), .I_g(g), .I_b(b),
    .I_test_en(test_en), .I_pat_sel(pat_sel),
    .O_lane0(lb0), .O_lane1(lb1),
    .O_lane2(lb2), .O_lane3(lb3),
    .O_clk_lane(clkb), .O_test_active(tb)
  );

  // Expected VESA words packed as {lane3,lane2,lane1,lane0}.
  function automatic logic [27:0] vmap(
    input logic dv, input logic hv, input logic vv,
    input logic [7:0] rv, input logic [7:0] gv, input logic [7:0] bv);
    logic [6:0] w0, w1, w2, w3;
    w0 = {gv[0], rv[5], rv[4], rv[3], rv[2], rv[1], rv[0]};
    w1 = {bv[1], bv[0], gv[5], gv[4], gv[3], gv[2], gv[1]};
    w2 = {dv, vv, hv, bv[5], bv[4], bv[3], bv[2]};
    w3 = {1'b0, bv[7], bv[6], gv[7], gv[6], rv[7], rv[6]};
    return {w3, w2, w1, w0};
  endfunction

  function automatic logic [23:0] bar_col(input int idx);
    case (idx)
      0: return 24'hFFFFFF;
      1: return 24'hFFFF00;
      2: return 24'h00FFFF;
      3: return 24'h00FF00;
      4: return 24'hFF00FF;
      5: return 24'hFF0000;
      6: return 24'h0000FF;
      default: return 24'h000000;
    endcase
  endfunction

  task automatic idle();
    de = 1'b0; hs = 1'b0; vs = 1'b0;
    r = 8'h00; g = 8'h00; b = 8'h00;
  endtask

  // VS pulse; test_en/pat_sel changed right after to prove they are latched.
  task automatic frame_start(input logic ten, input logic psel);
    @(negedge clk);
    idle();
    vs = 1'b1; test_en = ten; pat_sel = psel;
    @(negedge clk);
    vs = 1'b0; test_en = 1'b0; pat_sel = ~psel;
    @(negedge clk);
  endtask

  // kind 0 live data, 1 colour bars, 2 grey ramp.
  task automatic run_line(input int n, input int kind,
                          input logic tact, input string nm);
    logic [23:0] q[$];
    logic [23:0] e;
    logic [27:0] exp_w;
    logic [27:0] got;
    int c;
    for (int i = 0; i < n + 2; i++) begin
      @(negedge clk);
      if (i >= 2) begin
        e = q.pop_front();
        exp_w = vmap(1'b1, 1'b0, 1'b0, e[23:16], e[15:8], e[7:0]);
        got = {la3, la2, la1, la0};
        checks++;
        if (got !== exp_w) begin
          errors++;
          $display("FAIL %s px%0d lanes got %h want %h",
                   nm, i - 2, got, exp_w);
        end
        checks++;
        if (ta !== tact) begin
          errors++;
          $display("FAIL %s px%0d test_active got %b want %b",
                   nm, i - 2, ta, tact);
        end
      end
      if (i < n) begin
        de = 1'b1; hs = 1'b0; vs = 1'b0;
        r = 8'(i * 7 + 1); g = 8'h3C ^ 8'(i); b = 8'(255 - i);
        c = (i > 2047) ? 2047 : i;
        case (kind)
          0: q.push_back({r, g, b});
          1: q.push_back(bar_col(i / 4));
          default: q.push_back({3{8'(c)}});
        endcase
      end else begin
        idle();
      end
    end
  endtask

  task automatic test_reset();
    idle();
    rst = 1'b1; vs = 1'b1; test_en = 1'b1; pat_sel = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({la3, la2, la1, la0} !== 28'h0) begin
      errors++;
      $display("FAIL rst_lanes got %h want 0", {la3, la2, la1, la0});
    end
    checks++;
    if (ta !== 1'b0) begin
      errors++;
      $display("FAIL rst_test_active got %b want 0", ta);
    end
    checks++;
    if (clka !== 7'h63 || clkb !== 7'h63) begin
      errors++;
      $display("FAIL rst_clk_lane got %h/%h want 63", clka, clkb);
    end
    rst = 1'b0;
    @(negedge clk);
    vs = 1'b0; test_en = 1'b0;
    checks++;
    if (ta !== 1'b0) begin
      errors++;
      $display("FAIL post_rst_vs_lat1 got %b want 0", ta);
    end
    @(negedge clk);
    checks++;
    if (ta !== 1'b1) begin
      errors++;
      $display("FAIL post_rst_vs_start got %b want 1", ta);
    end
  endtask

  task automatic test_passthrough();
    frame_start(1'b0, 1'b0);
    repeat (2) @(negedge clk);
    de = 1'b1; r = 8'hA5; g = 8'h3C; b = 8'hF0;
    @(negedge clk);
    idle();
    checks++;
    if (la0 !== 7'h00) begin
      errors++;
      $display("FAIL pass_latency lane0 got %h want 00", la0);
    end
    @(negedge clk);
    checks++;
    if ({la3, la2, la1, la0} !== {7'h32, 7'h4C, 7'h1E, 7'h25}) begin
      errors++;
      $display("FAIL vesa_pass got %h %h %h %h want 32 4c 1e 25",
               la3, la2, la1, la0);
    end
    checks++;
    if ({lb3, lb2, lb1, lb0} !== {7'h01, 7'h7F, 7'h07, 7'h69}) begin
      errors++;
      $display("FAIL jeida_inv got %h %h %h %h want 01 7f 07 69",
               lb3, lb2, lb1, lb0);
    end
    checks++;
    if (clka !== 7'h63 || clkb !== 7'h63 || ta !== 1'b0) begin
      errors++;
      $display("FAIL pass_clk_ta got %h/%h %b want 63 0",
               clka, clkb, ta);
    end
  endtask

  task automatic test_color_bars();
    frame_start(1'b1, 1'b0);
    run_line(40, 1, 1'b1, "bars");
    @(negedge clk);
    de = 1'b0; r = 8'hFF; g = 8'hFF; b = 8'hFF;
    @(negedge clk);
    idle();
    @(negedge clk);
    checks++;
    if ({la3, la2, la1, la0} !== 28'h0 || ta !== 1'b1) begin
      errors++;
      $display("FAIL blank_black got %h ta %b want 0 ta 1",
               {la3, la2, la1, la0}, ta);
    end
  endtask

  task automatic test_mid_frame();
    frame_start(1'b0, 1'b0);
    test_en = 1'b1;
    run_line(6, 0, 1'b0, "mid_live");
    frame_start(1'b1, 1'b0);
    run_line(10, 1, 1'b1, "next_bars");
  endtask

  task automatic test_ramp();
    frame_start(1'b1, 1'b1);
    run_line(2100, 2, 1'b1, "ramp");
  endtask

  task automatic test_reset_midline();
    frame_start(1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      de = 1'b1; r = 8'h11; g = 8'h22; b = 8'h33;
    end
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle();
    checks++;
    if ({la3, la2, la1, la0} !== 28'h0 || ta !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid got %h ta %b want 0 ta 0",
               {la3, la2, la1, la0}, ta);
    end
    checks++;
    if (clka !== 7'h63) begin
      errors++;
      $display("FAIL rst_mid_clk got %h want 63", clka);
    end
    test_en = 1'b1;
    run_line(6, 0, 1'b0, "post_rst_live");
    frame_start(1'b1, 1'b0);
    run_line(8, 1, 1'b1, "post_rst_bars");
  endtask

  initial begin
    rst = 1'b1;
    test_en = 1'b0;
    pat_sel = 1'b0;
    idle();
    test_reset();
    test_passthrough();
    test_color_bars();
    test_mid_frame();
    test_ramp();
    test_reset_midline();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
